// File: rtl/sincronizador_desrebotador_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sincronizador_desrebotador_pkg
// Purpose  : Shared definitions for the debouncing front end: debounce FSM
//            state encodings and the helper that sizes the validation counter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sincronizador_desrebotador_pkg;

  // Debounce FSM states. The encoding is fixed so that debug tools and other
  // blocks reading the state see the same values.
  typedef enum logic [1:0] {
    ESTABLE_BAJO   = 2'd0,
    VALIDANDO_ALTO = 2'd1,
    ESTABLE_ALTO   = 2'd2,
    VALIDANDO_BAJO = 2'd3
  } estado_t;

  // Width of a counter that has to reach ciclos-1. $clog2(1) is 0, and a
  // zero-width vector is illegal, so the width is clamped to at least 1.
  function automatic int ancho_contador(input int ciclos);
    int w;
    w = $clog2(ciclos);
    return (w == 0) ? 1 : w;
  endfunction

endpackage : sincronizador_desrebotador_pkg
`default_nettype wire

// File: rtl/sincronizador_desrebotador_sincronizador.sv
`default_nettype none
// ============================================================================
// Module   : sincronizador
// Purpose  : Plain flip-flop chain that brings an asynchronous input into the
//            clk domain. Reusable for any external asynchronous level.
// Ports    : clk                 - system clock, rising edge
//            reset               - asynchronous, active-high; clears the chain
//            entrada_asincronica - raw asynchronous input
//            salida_sincronica   - output of the last stage
// Revision : 1.0 - initial release
// ============================================================================
module sincronizador #(
  parameter int ETAPAS_SINC = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic entrada_asincronica,
  output logic salida_sincronica
);

  logic [ETAPAS_SINC-1:0] r_etapas;

  // Pure shift register: nothing may sit between stages, otherwise the
  // metastability resolution time of the chain is reduced.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_etapas <= '0;
    end else begin
      r_etapas <= {r_etapas[ETAPAS_SINC-2:0], entrada_asincronica};
    end
  end

  assign salida_sincronica = r_etapas[ETAPAS_SINC-1];

endmodule : sincronizador
`default_nettype wire

// File: rtl/sincronizador_desrebotador.sv
`default_nettype none
// ============================================================================
// Module   : sincronizador_desrebotador
// Purpose  : Button / external-input front end. Synchronises the raw input,
//            then only lets the clean output follow once the synchronised
//            level has held for CICLOS_ESTABLES consecutive cycles. Emits a
//            one-cycle pulse on each change of the clean level.
// Ports    : clk                            - system clock, rising edge
//            reset                          - asynchronous, active-high
//            entrada_asincronica            - raw, bouncing input
//            entrada_sincronica_desrebotada - registered debounced level
//            pulso_cambio                   - registered one-cycle change pulse
//            validando                      - high in a VALIDANDO_* state
// Revision : 1.0 - initial release
// ============================================================================
module sincronizador_desrebotador
  import sincronizador_desrebotador_pkg::*;
#(
  parameter int ETAPAS_SINC     = 2,
  parameter int CICLOS_ESTABLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic entrada_asincronica,
  output logic entrada_sincronica_desrebotada,
  output logic pulso_cambio,
  output logic validando
);

  localparam int ANCHO_CONTADOR = ancho_contador(CICLOS_ESTABLES);
  localparam logic [ANCHO_CONTADOR-1:0] c_cuenta_final =
    ANCHO_CONTADOR'(CICLOS_ESTABLES - 1);

  logic                      w_sinc;
  estado_t                   r_estado;
  logic [ANCHO_CONTADOR-1:0] r_contador;
  logic                      r_salida;
  logic                      r_pulso;

  sincronizador #(
    .ETAPAS_SINC (ETAPAS_SINC)
  ) u_sincronizador (
    .clk                 (clk),
    .reset               (reset),
    .entrada_asincronica (entrada_asincronica),
    .salida_sincronica   (w_sinc)
  );

  // The counter is cleared on every entry into a VALIDANDO state and the
  // transition completes when it reaches c_cuenta_final, so it can never
  // wrap. A bounce back to the old level drops straight to the stable state,
  // discarding any partial count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado   <= ESTABLE_BAJO;
      r_contador <= '0;
      r_salida   <= 1'b0;
      r_pulso    <= 1'b0;
    end else begin
      r_pulso <= 1'b0;
      case (r_estado)
        ESTABLE_BAJO: begin
          if (w_sinc) begin
            r_estado   <= VALIDANDO_ALTO;
            r_contador <= '0;
          end
        end
        VALIDANDO_ALTO: begin
          if (!w_sinc) begin
            r_estado   <= ESTABLE_BAJO;
            r_contador <= '0;
          end else if (r_contador == c_cuenta_final) begin
            r_estado   <= ESTABLE_ALTO;
            r_contador <= '0;
            r_salida   <= 1'b1;
            r_pulso    <= 1'b1;
          end else begin
            r_contador <= r_contador + 1'b1;
          end
        end
        ESTABLE_ALTO: begin
          if (!w_sinc) begin
            r_estado   <= VALIDANDO_BAJO;
            r_contador <= '0;
          end
        end
        VALIDANDO_BAJO: begin
          if (w_sinc) begin
            r_estado   <= ESTABLE_ALTO;
            r_contador <= '0;
          end else if (r_contador == c_cuenta_final) begin
            r_estado   <= ESTABLE_BAJO;
            r_contador <= '0;
            r_salida   <= 1'b0;
            r_pulso    <= 1'b1;
          end else begin
            r_contador <= r_contador + 1'b1;
          end
        end
        default: begin
          // Corrupted state: fall back to a known low, stable condition.
          r_estado   <= ESTABLE_BAJO;
          r_contador <= '0;
          r_salida   <= 1'b0;
        end
      endcase
    end
  end

  assign entrada_sincronica_desrebotada = r_salida;
  assign pulso_cambio                   = r_pulso;

  // Decoded from the state register only, so it carries no input path.
  assign validando = (r_estado == VALIDANDO_ALTO) ||
                     (r_estado == VALIDANDO_BAJO);

endmodule : sincronizador_desrebotador
`default_nettype wire

// File: tb/tb_sincronizador_desrebotador.sv
`default_nettype none
// ============================================================================
// Module   : tb_sincronizador_desrebotador
// Purpose  : Self-checking bench for sincronizador_desrebotador with
//            ETAPAS_SINC=2, CICLOS_ESTABLES=4 (7-edge latency).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sincronizador_desrebotador;

  logic clk;
  logic reset;
  logic entrada_asincronica;
  logic entrada_sincronica_desrebotada;
  logic pulso_cambio;
  logic validando;

  int checks = 0;
  int errors = 0;
  int ciclo  = 0;   // number of rising edges seen so far
  int base   = 0;   // edge count at the moment a scenario drives its stimulus

  typedef struct {
    int ciclo;
    bit o;
    bit p;
    bit v;
    bit cv;   // compare validando as well
  } punto_t;

  typedef struct {
    int ciclo;
    bit nivel;
  } pulso_t;

  punto_t q_puntos[$];
  pulso_t q_pulsos[$];

  sincronizador_desrebotador #(
    .ETAPAS_SINC     (2),
    .CICLOS_ESTABLES (4)
  ) dut (
    .clk                            (clk),
    .reset                          (reset),
    .entrada_asincronica            (entrada_asincronica),
    .entrada_sincronica_desrebotada (entrada_sincronica_desrebotada),
    .pulso_cambio                   (pulso_cambio),
    .validando                      (validando)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ciclo <= ciclo + 1;

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin : monitor
    pulso_t e;
    punto_t p;
    if (pulso_cambio) begin
      checks++;
      if (q_pulsos.size() == 0) begin
        errors++;
        $display("FAIL pulso_inesperado: pulse at edge %0d level %0b, none expected",
                 ciclo, entrada_sincronica_desrebotada);
      end else begin
        e = q_pulsos.pop_front();
        if (e.ciclo != ciclo || e.nivel != entrada_sincronica_desrebotada) begin
          errors++;
          $display("FAIL pulso: got edge %0d level %0b, expected edge %0d level %0b",
                   ciclo, entrada_sincronica_desrebotada, e.ciclo, e.nivel);
        end
      end
    end
    while (q_puntos.size() > 0 && q_puntos[0].ciclo <= ciclo) begin
      p = q_puntos.pop_front();
      checks++;
      if (p.ciclo != ciclo ||
          entrada_sincronica_desrebotada != p.o ||
          pulso_cambio != p.p ||
          (p.cv && validando != p.v)) begin
        errors++;
        $display("FAIL punto edge %0d (at %0d): got out=%0b pulse=%0b val=%0b, expected out=%0b pulse=%0b val=%0b",
                 p.ciclo, ciclo, entrada_sincronica_desrebotada, pulso_cambio,
                 validando, p.o, p.p, p.v);
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic sig();
    @(negedge clk);
    #1;
  endtask

  task automatic punto(input int dc, input bit o, input bit p, input bit v);
    punto_t x;
    x.ciclo = base + dc; x.o = o; x.p = p; x.v = v; x.cv = 1'b1;
    q_puntos.push_back(x);
  endtask

  task automatic punto_sin_v(input int dc, input bit o, input bit p);
    punto_t x;
    x.ciclo = base + dc; x.o = o; x.p = p; x.v = 1'b0; x.cv = 1'b0;
    q_puntos.push_back(x);
  endtask

  task automatic espera_pulso(input int dc, input bit nivel);
    pulso_t x;
    x.ciclo = base + dc; x.nivel = nivel;
    q_pulsos.push_back(x);
  endtask

  // Clean step to 'nivel' held 20 cycles: validando over edges 3..6,
  // output and pulse on edge 7.
  task automatic escalon(input bit nivel);
    base = ciclo;
    entrada_asincronica = nivel;
    punto(2, !nivel, 1'b0, 1'b0);
    punto(3, !nivel, 1'b0, 1'b1);
    punto(6, !nivel, 1'b0, 1'b1);
    punto(7,  nivel, 1'b1, 1'b0);
    punto(8,  nivel, 1'b0, 1'b0);
    espera_pulso(7, nivel);
    repeat (20) sig();
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin : estimulo
    bit rebote [6];
    int r;
    rebote = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    reset = 1'b1;
    entrada_asincronica = 1'b0;
    base = 0;
    punto(1, 1'b0, 1'b0, 1'b0);
    punto(2, 1'b0, 1'b0, 1'b0);
    sig(); sig();
    reset = 1'b0;
    repeat (3) sig();

    // Clean rise, then clean fall.
    escalon(1'b1);
    escalon(1'b0);

    // 3-cycle glitch high: validates for three edges, then rejected.
    base = ciclo;
    entrada_asincronica = 1'b1;
    punto(3,  1'b0, 1'b0, 1'b1);
    punto(5,  1'b0, 1'b0, 1'b1);
    punto(6,  1'b0, 1'b0, 1'b0);
    punto(15, 1'b0, 1'b0, 1'b0);
    repeat (3) sig();
    entrada_asincronica = 1'b0;
    repeat (20) sig();

    // Bouncing rise: 1,0,1,1,0 then stable 1 from index 5 -> output at +12.
    base = ciclo;
    punto(3,  1'b0, 1'b0, 1'b1);
    punto(4,  1'b0, 1'b0, 1'b0);
    punto(6,  1'b0, 1'b0, 1'b1);
    punto(7,  1'b0, 1'b0, 1'b0);
    punto(8,  1'b0, 1'b0, 1'b1);
    punto(11, 1'b0, 1'b0, 1'b1);
    punto(12, 1'b1, 1'b1, 1'b0);
    punto(13, 1'b1, 1'b0, 1'b0);
    espera_pulso(12, 1'b1);
    for (int k = 0; k < 6; k++) begin
      entrada_asincronica = rebote[k];
      sig();
    end
    repeat (20) sig();

    escalon(1'b0);

    // Asynchronous reset mid-validation (contador=2 after edge 5).
    base = ciclo;
    entrada_asincronica = 1'b1;
    punto(4, 1'b0, 1'b0, 1'b1);
    punto(5, 1'b0, 1'b0, 1'b0);   // reset lands between edge 5 and this sample
    punto(6, 1'b0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;
    r = ciclo;
    base = r;
    punto(2, 1'b0, 1'b0, 1'b0);
    punto(3, 1'b0, 1'b0, 1'b1);
    punto(6, 1'b0, 1'b0, 1'b1);
    punto(7, 1'b1, 1'b1, 1'b0);
    espera_pulso(7, 1'b1);
    repeat (20) sig();

    escalon(1'b0);

    // Toggle every cycle for 100 cycles: output constant low, no pulses.
    base = ciclo;
    for (int k = 1; k <= 10; k++) punto_sin_v(10 * k, 1'b0, 1'b0);
    for (int k = 0; k < 100; k++) begin
      entrada_asincronica = ~entrada_asincronica;
      sig();
    end
    entrada_asincronica = 1'b0;
    base = ciclo;
    punto(6, 1'b0, 1'b0, 1'b0);
    repeat (10) sig();

    checks++;
    if (q_pulsos.size() != 0) begin
      errors++;
      $display("FAIL pulsos_pendientes: %0d expected pulses never seen, required 0",
               q_pulsos.size());
    end
    checks++;
    if (q_puntos.size() != 0) begin
      errors++;
      $display("FAIL puntos_pendientes: %0d checkpoints never sampled, required 0",
               q_puntos.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : vigilante
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "time limit");
  end

endmodule : tb_sincronizador_desrebotador
`default_nettype wire
